// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the processor data path and the data-memory arbiter.
// Holds the data width, arbiter mode encoding, default starvation/burst limits
// and a counter-width helper used to size the saturating counters.
package dmem_arbiter_pkg;

  // Processor data path width (address and data words).
  localparam int XLEN = 32;

  // Arbiter defaults.
  localparam int STARVE_MAX_DEF = 4;
  localparam int BURST_MAX_DEF  = 8;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } arb_mode_t;

  // Bits needed to hold a counter that saturates at max_val (always >= 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU port, DMA port and the single-port data memory.
// Ports: cpu_* (request/we/addr/wdata in, rdata/stall out), dma_* (request/we/lock/
// addr/wdata in, rdata/gnt out), mem_* (we/addr/wdata out, rdata in) as seen by the arbiter.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic            cpu_req;
  logic            cpu_we;
  logic [XLEN-1:0] cpu_addr;
  logic [XLEN-1:0] cpu_wdata;
  logic [XLEN-1:0] cpu_rdata;
  logic            cpu_stall;

  logic            dma_req;
  logic            dma_we;
  logic            dma_lock;
  logic [XLEN-1:0] dma_addr;
  logic [XLEN-1:0] dma_wdata;
  logic [XLEN-1:0] dma_rdata;
  logic            dma_gnt;

  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_rdata, dma_gnt,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory side (environment around the arbiter).
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_rdata, dma_gnt,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port data memory.
// Grants are combinational from the current mode/counters; reads return in the grant cycle.
// Ports: clk, reset (sync, active-low), bus (dmem_arbiter_if.slave). A losing CPU sees cpu_stall,
// a losing DMA sees dma_gnt low; both must hold their request until granted.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int BURST_MAX  = BURST_MAX_DEF
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int SW = cnt_width(STARVE_MAX);
  localparam int BW = cnt_width(BURST_MAX);

  arb_mode_t       mode;
  logic [SW-1:0]   starve_cnt;
  logic [BW-1:0]   burst_cnt;

  logic            starve_full;
  logic            burst_full;
  logic            cpu_gnt;
  logic            dma_gnt;

  assign starve_full = (starve_cnt == SW'(STARVE_MAX));
  assign burst_full  = (burst_cnt  == BW'(BURST_MAX));

  // Grant decision. Reset suppresses every grant so nothing reaches memory
  // and no stall is reported while the block is held in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (reset) begin
      case (mode)
        S_IDLE: begin
          // CPU wins ties until the DMA has lost STARVE_MAX contended cycles.
          if (bus.dma_req && (!bus.cpu_req || starve_full)) dma_gnt = 1'b1;
          else if (bus.cpu_req)                              cpu_gnt = 1'b1;
        end
        S_BURST: begin
          // Locked burst keeps the DMA on the bus until the length cap is hit
          // while the CPU is waiting.
          if (bus.dma_req && !(burst_full && bus.cpu_req)) dma_gnt = 1'b1;
          else if (bus.cpu_req)                            cpu_gnt = 1'b1;
        end
        default: begin
          cpu_gnt = 1'b0;
          dma_gnt = 1'b0;
        end
      endcase
    end
  end

  // Memory-side mux: only the granted port can drive a write.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (dma_gnt) begin
      bus.mem_we    = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end else if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt & reset;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode       <= S_IDLE;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else begin
      if (dma_gnt)                         starve_cnt <= '0;
      else if (bus.dma_req && !starve_full) starve_cnt <= starve_cnt + SW'(1);

      case (mode)
        S_IDLE: begin
          if (dma_gnt && bus.dma_lock) begin
            mode      <= S_BURST;
            burst_cnt <= BW'(1);
          end
        end
        S_BURST: begin
          // Leave on: DMA drops its request, an unlocked grant, or a forced
          // release (DMA requesting but not granted).
          if (!bus.dma_req || !dma_gnt || !bus.dma_lock) begin
            mode      <= S_IDLE;
            burst_cnt <= '0;
          end else if (!burst_full) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        default: begin
          mode      <= S_IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] mem [0:255];

  dmem_arbiter_if bus();

  dmem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: synchronous write, combinational read, word addressed.
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_lock  = lock;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
  endtask

  // Expected outputs derived from the stimulus and the expected winner.
  task automatic chk_gnt(input string tag, input bit ed, input bit ec);
    logic [31:0] ea;
    logic [31:0] ewd;
    logic        ew;
    ea  = ed ? bus.dma_addr  : (ec ? bus.cpu_addr  : 32'h0);
    ewd = ed ? bus.dma_wdata : (ec ? bus.cpu_wdata : 32'h0);
    ew  = ed ? bus.dma_we    : (ec ? bus.cpu_we    : 1'b0);
    chk({tag, " dma_gnt"},   {31'h0, bus.dma_gnt},   {31'h0, ed});
    chk({tag, " cpu_stall"}, {31'h0, bus.cpu_stall}, {31'h0, bus.cpu_req & ~ec});
    chk({tag, " mem_we"},    {31'h0, bus.mem_we},    {31'h0, ew});
    chk({tag, " mem_addr"},  bus.mem_addr,  ea);
    chk({tag, " mem_wdata"}, bus.mem_wdata, ewd);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " dma_gnt"},   {31'h0, bus.dma_gnt},   32'h0);
    chk({tag, " mem_we"},    {31'h0, bus.mem_we},    32'h0);
    chk({tag, " cpu_stall"}, {31'h0, bus.cpu_stall}, 32'h0);
  endtask

  bit starve_d [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  bit tail_d   [5]  = '{0, 0, 0, 0, 1};

  initial begin
    total = 0;
    bad   = 0;

    // Reset with both ports requesting writes: nothing may be granted.
    reset = 1'b0;
    set_cpu(1'b1, 1'b1, 32'h54, 32'h7);
    set_dma(1'b1, 1'b1, 1'b0, 32'h80, 32'hAA);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk_rst($sformatf("reset%0d", i));
    end

    // Idle: no requests.
    @(negedge clk);
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk_gnt($sformatf("idle%0d", i), 1'b0, 1'b0);
    end

    // CPU alone writes 7 to 0x54 every cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_cpu(1'b1, 1'b1, 32'h54, 32'h7);
      #1;
      chk_gnt($sformatf("cpu_only%0d", i), 1'b0, 1'b1);
      chk("cpu_only mem_we literal", {31'h0, bus.mem_we}, 32'h1);
      chk("cpu_only addr literal", bus.mem_addr, 32'h54);
    end

    // CPU read-back; rdata goes to both ports.
    @(negedge clk);
    set_cpu(1'b1, 1'b0, 32'h54, 32'h0);
    #1;
    chk_gnt("cpu_rd", 1'b0, 1'b1);
    chk("cpu_rd cpu_rdata", bus.cpu_rdata, 32'h7);
    chk("cpu_rd dma_rdata", bus.dma_rdata, 32'h7);

    // Starvation: both request, CPU writes 0x60, DMA writes 0x80.
    // The CPU's data changes to 0x22 on the cycle it is stalled.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_cpu(1'b1, 1'b1, 32'h60, (i >= 4) ? 32'h22 : 32'h11);
      set_dma(1'b1, 1'b1, 1'b0, 32'h80, 32'hAA);
      #1;
      chk_gnt($sformatf("starve%0d", i), starve_d[i], !starve_d[i]);
      if (i == 5) begin
        chk("stalled write mem60", mem[24], 32'h11);
        chk("dma write mem80", mem[32], 32'hAA);
      end
      if (i == 6) chk("late cpu write mem60", mem[24], 32'h22);
    end

    // Locked DMA read burst; CPU starts requesting on cycle 3.
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      set_dma(1'b1, 1'b0, 1'b1, 32'h80, 32'h0);
      set_cpu(c >= 3, 1'b0, 32'h54, 32'h0);
      #1;
      chk_gnt($sformatf("burst%0d", c), c <= 8, c >= 9);
      if (c == 1) chk("burst dma_rdata", bus.dma_rdata, 32'hAA);
      if (c == 9) chk("release cpu_rdata", bus.cpu_rdata, 32'h7);
    end

    // No requests: starvation count (2) must hold, so contention gives C C D.
    @(negedge clk);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk_gnt("hold idle", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_cpu(1'b1, 1'b0, 32'h54, 32'h0);
      set_dma(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
      #1;
      chk_gnt($sformatf("hold%0d", i), i == 2, i != 2);
    end

    // Reset on burst cycle 4; burst restarts and runs a full 8 grants.
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      reset = (c != 4);
      set_dma(1'b1, 1'b1, 1'b1, 32'h84, 32'h5 + c);
      set_cpu((c == 4) || (c >= 6), 1'b0, 32'h54, 32'h0);
      #1;
      if (c == 4) chk_rst("mid_burst reset");
      else chk_gnt($sformatf("rburst%0d", c), (c <= 3) || (c >= 5 && c <= 12), c == 13);
    end

    // Starvation counter at 1: two CPU wins take it to 3, then reset must clear it.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1;
      set_cpu(1'b1, 1'b0, 32'h54, 32'h0);
      set_dma(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
      #1;
      chk_gnt($sformatf("pre%0d", i), 1'b0, 1'b1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_rst("starve reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_gnt($sformatf("post%0d", i), tail_d[i], !tail_d[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: contended cycles the DMA port may lose before it is forced a grant.
REQ-002 SHALL have parameter BURST_MAX, default 8: maximum consecutive locked DMA grants.
REQ-003 SHALL have port clk  in  1: single clock, rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-low reset (0 = reset).
REQ-005 SHALL have ports cpu_req, cpu_we  in  1: CPU access request and write enable.
REQ-006 SHALL have ports cpu_addr, cpu_wdata  in  32: CPU address and write data.
REQ-007 SHALL have ports cpu_rdata  out  32 and cpu_stall  out  1: CPU read data and stall (hold the CPU PC).
REQ-008 SHALL have ports dma_req, dma_we, dma_lock  in  1: DMA request, write enable and burst lock.
REQ-009 SHALL have ports dma_addr, dma_wdata  in  32 and dma_rdata  out  32, dma_gnt  out  1.
REQ-010 SHALL have ports mem_we  out  1, mem_addr, mem_wdata  out  32, mem_rdata  in  32: single-port data-memory side (synchronous write, combinational read).

Function
REQ-011 SHALL hold registered state: mode {S_IDLE, S_BURST}, starve_cnt (0..STARVE_MAX, saturating), burst_cnt (0..BURST_MAX).
REQ-012 SHALL decide grants combinationally from current state and requests; zero-latency grant, reads return in the grant cycle.
REQ-013 In S_IDLE: DMA granted if dma_req and (not cpu_req or starve_cnt == STARVE_MAX); otherwise CPU granted if cpu_req; otherwise no grant.
REQ-014 In S_BURST: DMA granted if dma_req, except when burst_cnt == BURST_MAX and cpu_req, where CPU is granted (forced release).
REQ-015 SHALL drive mem_we = granted port's we; mem_addr/mem_wdata = granted port's values; all zero when no grant.
REQ-016 SHALL drive cpu_stall = cpu_req and not CPU-granted; dma_gnt = DMA-granted.
REQ-017 SHALL route mem_rdata to both cpu_rdata and dma_rdata unconditionally; data is valid only for the granted port.
REQ-018 starve_cnt SHALL increment when dma_req and not DMA-granted, clear on any DMA grant, hold otherwise.
REQ-019 Transition S_IDLE -> S_BURST when DMA granted and dma_lock = 1; burst_cnt loads 1.
REQ-020 In S_BURST each DMA grant with dma_lock = 1 SHALL increment burst_cnt (saturate at BURST_MAX).
REQ-021 S_BURST -> S_IDLE when dma_req = 0, dma_lock = 0 on a grant, or forced release; burst_cnt clears.
REQ-022 A non-granted requester SHALL hold its request; the arbiter never drops a pending request.
REQ-023 Simultaneous cpu_req and dma_req with starve_cnt < STARVE_MAX in S_IDLE SHALL grant CPU.
REQ-024 Writes SHALL occur only via mem_we on the granted cycle; a stalled write SHALL never reach memory.

Reset
REQ-025 While reset = 0 at a rising edge: mode <= S_IDLE, starve_cnt <= 0, burst_cnt <= 0.
REQ-026 While reset = 0, dma_gnt = 0, mem_we = 0, cpu_stall = 0 regardless of requests.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; the first cycle after release behaves as S_IDLE with zero counters.

Structure
REQ-028 Mode encoding and STARVE_MAX/BURST_MAX defaults SHALL live in a shared package with the processor's constants.
REQ-029 SHALL be one module; the grant/mux logic and state registers need no sub-module.
REQ-030 SHALL sit between mips and dmem in the top level, with cpu_stall gating the PC register enable.

Verification
REQ-031 CPU-only: cpu_req = 1, cpu_we = 1, addr 0x54, wdata 7 -> mem_we = 1, mem_addr 0x54, cpu_stall = 0 every cycle.
REQ-032 Starvation: both requesting continuously, no lock -> CPU granted 4 cycles, DMA granted on the 5th (cpu_stall = 1), pattern repeats.
REQ-033 Burst: DMA alone with dma_lock = 1 for 10 cycles, cpu_req rising at cycle 3 -> DMA granted cycles 1-8, CPU granted cycle 9, DMA re-arbitrated after.
REQ-034 Stalled write: DMA forced grant while cpu_we = 1, addr 0x60 -> mem_addr = DMA address, no write to 0x60 that cycle, CPU write lands next cycle.
REQ-035 Reset mid-burst: reset = 0 at burst cycle 4 for 1 cycle -> dma_gnt = 0, mem_we = 0 that cycle; afterwards starve_cnt = 0, burst restarts at burst_cnt 1.
REQ-036 Idle: no requests -> mem_we = 0, mem_addr = 0, dma_gnt = 0, cpu_stall = 0, counters unchanged.
